led_trail_pwm: RTL



---
 rtl/led_pkg.sv | 18 +
 rtl/led_fade_cell.sv | 62 ++++++
 rtl/led_trail_pwm.sv | 66 ++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED trail PWM output stage.
// gamma_map is referenced only when LED_GAMMA_EN is defined.
package led_pkg;

  localparam int unsigned LVL_W_DEF = 4;

  function automatic int unsigned lvl_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  // Quadratic brightness map: keeps e(0)=0 and e(MAX)=MAX and is monotonic.
  function automatic int unsigned gamma_map(input int unsigned lvl, input int unsigned width);
    int unsigned sq;
    sq = (lvl * lvl) + lvl_max(width);
    return sq >> width;
  endfunction

endpackage

// File: rtl/led_fade_cell.sv
// One LED lane: brightness level register, fade rule and registered PWM compare.
// LED_GAMMA_EN selects the quadratic brightness map; otherwise the level drives PWM linearly.
module led_fade_cell
  import led_pkg::*;
#(
  parameter int unsigned LVL_W = LVL_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             tick_i,
  input  logic [LVL_W-1:0] pcnt_i,
  input  logic             pattern_i,
  output logic             led_o
);

  localparam logic [LVL_W-1:0] MAX = LVL_W'(lvl_max(LVL_W));

  logic [LVL_W-1:0] lvl_q;
  logic [LVL_W-1:0] lvl_d;
  logic             led_q;
  logic             led_d;
  logic [LVL_W-1:0] eff_s;

`ifdef LED_GAMMA_EN
  assign eff_s = LVL_W'(gamma_map(32'(lvl_q), LVL_W));
`else
  assign eff_s = lvl_q;
`endif

  // Pattern reloads full brightness and wins over the fade tick; fading stops at zero.
  always_comb begin
    lvl_d = lvl_q;
    led_d = 1'b0;
    if (en_i) begin
      if (pattern_i) begin
        lvl_d = MAX;
      end else if (tick_i && (lvl_q != {LVL_W{1'b0}})) begin
        lvl_d = lvl_q - LVL_W'(1);
      end else begin
        lvl_d = lvl_q;
      end
      led_d = (eff_s > pcnt_i);
    end else begin
      lvl_d = lvl_q;
      led_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl_q <= {LVL_W{1'b0}};
      led_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
      led_q <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_trail_pwm.sv
// LED comet-tail output stage: shared decay timer and PWM counter feeding one fade cell per LED.
// Optional build macro LED_GAMMA_EN enables gamma-corrected brightness in every cell.
module led_trail_pwm
  import led_pkg::*;
#(
  parameter int unsigned BITS      = 10,
  parameter int unsigned LVL_W     = LVL_W_DEF,
  parameter int unsigned DECAY_CYC = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [BITS-1:0] pattern,
  output logic [BITS-1:0] led
);

  localparam int unsigned      DW    = $clog2(DECAY_CYC + 1);
  localparam logic [DW-1:0]    DLAST = DW'(DECAY_CYC - 1);
  localparam logic [LVL_W-1:0] PLAST = LVL_W'(lvl_max(LVL_W) - 1);

  logic [DW-1:0]    dcnt_q;
  logic [DW-1:0]    dcnt_d;
  logic [LVL_W-1:0] pcnt_q;
  logic [LVL_W-1:0] pcnt_d;
  logic             tick_s;

  assign tick_s = (dcnt_q == DLAST);

  // Both counters freeze while disabled and resume from the held values.
  always_comb begin
    dcnt_d = dcnt_q;
    pcnt_d = pcnt_q;
    if (en) begin
      dcnt_d = tick_s ? {DW{1'b0}} : (dcnt_q + DW'(1));
      pcnt_d = (pcnt_q == PLAST) ? {LVL_W{1'b0}} : (pcnt_q + LVL_W'(1));
    end else begin
      dcnt_d = dcnt_q;
      pcnt_d = pcnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_q <= {DW{1'b0}};
      pcnt_q <= {LVL_W{1'b0}};
    end else begin
      dcnt_q <= dcnt_d;
      pcnt_q <= pcnt_d;
    end
  end

  for (genvar i = 0; i < BITS; i++) begin : g_cell
    led_fade_cell #(
      .LVL_W(LVL_W)
    ) u_cell (
      .clk_i    (clk),
      .rst_i    (rst),
      .en_i     (en),
      .tick_i   (tick_s),
      .pcnt_i   (pcnt_q),
      .pattern_i(pattern[i]),
      .led_o    (led[i])
    );
  end

endmodule
